sevseg_mux_driver: RTL
======================

SEVSEG_MUX_DRIVER -- requirements
Module: sevseg_mux_driver

Interface
REQ-001 Parameter NUM_DIGITS, 2, number of multiplexed digits (1..8).
REQ-002 Parameter REFRESH_DIV, 1000, clk cycles each digit is driven (ON phase), >=1.
REQ-003 Parameter DEAD_CYCLES, 2, clk cycles of all-off gap between digits (anti-ghosting), >=0.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 hex_in  input  4*NUM_DIGITS  hex nibbles; digit k = hex_in[4k+3:4k], digit 0 least significant.
REQ-007 blank_in  input  NUM_DIGITS  per-digit blank request, 1 = digit dark.
REQ-008 load  input  1  capture strobe for hex_in/blank_in.
REQ-009 seg  output  7  active-low segments, bit0=a .. bit6=g, registered.
REQ-010 an  output  NUM_DIGITS  active-low digit enables, one-cold or all-ones, registered.
REQ-011 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-012 load=1 at an edge SHALL copy hex_in/blank_in into a shadow register; no handshake, every load accepted.
REQ-013 Shadow SHALL transfer to the display register only on entry to an ON phase; a load on the same edge as ON entry takes effect at the next ON entry.
REQ-014 FSM states ON and DEAD; ON lasts REFRESH_DIV cycles, then DEAD for DEAD_CYCLES cycles, then ON for next digit.
REQ-015 With DEAD_CYCLES=0 the DEAD state SHALL be skipped; ON-to-ON transitions back to back.
REQ-016 Digit index SHALL increment at each ON entry, wrapping NUM_DIGITS-1 -> 0; NUM_DIGITS=1 stays at 0.
REQ-017 In ON: an bit of current digit =0, others 1; seg = decoded nibble, or 7'h7F if blanked.
REQ-018 In DEAD: an and seg all ones.
REQ-019 Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 Outputs SHALL lag internal state by exactly one clk (registered).
REQ-021 frame_done SHALL pulse high one cycle, the same cycle an shows digit 0's first ON cycle following digit NUM_DIGITS-1.
REQ-022 Refresh counter width SHALL be $clog2 of max(REFRESH_DIV, DEAD_CYCLES)+1; no overflow for any legal parameter.

Reset
REQ-023 While reset=0 at an edge: seg=7'h7F, an all ones, frame_done=0, shadow and display registers zero, blank none, digit index 0, state ON, counter 0.
REQ-024 First edge with reset=1 SHALL start digit 0 ON; an shows digit 0 one cycle later.
REQ-025 Reset asserted mid-ON or mid-DEAD SHALL abort immediately with no frame_done.

Configuration
REQ-026 Macro SEVSEG_LEADING_ZERO_BLANK_EN: when defined, any digit whose nibble is 0 and all higher digits are 0 SHALL be blanked, except digit 0 which always shows.
REQ-027 Without SEVSEG_LEADING_ZERO_BLANK_EN, blanking SHALL come from blank_in only; zeros display as 1000000.

Verification (NUM_DIGITS=2, REFRESH_DIV=4, DEAD_CYCLES=1 unless noted)
REQ-028 Reset then load hex_in=8'hF1 -> an=10 with seg=1111001 for 4 cycles, all-ones 1 cycle, an=01 with seg=0001110 for 4 cycles, frame_done pulse on next an=10.
REQ-029 Load 8'h3C mid digit-0 ON -> digit 0 keeps old value until its period ends; digit 1 next shows 0110000.
REQ-030 blank_in=2'b10, hex_in=8'h88 -> digit 1 slot an=01, seg=1111111; digit 0 seg=0000000.
REQ-031 Reset=0 asserted during DEAD -> next cycle seg=1111111, an=11, frame_done=0; restart at digit 0.
REQ-032 DEAD_CYCLES=0, NUM_DIGITS=4 -> an sequence 1110,1101,1011,0111 each 4 cycles, no all-ones gap.
REQ-033 With SEVSEG_LEADING_ZERO_BLANK_EN, hex_in=8'h05 -> digit 1 dark, digit 0 seg=0010010; hex_in=8'h00 -> digit 0 shows 1000000.

Source files
------------

// File: rtl/sevseg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_mux_driver
// Description : Time-multiplexed seven-segment driver with dead-time gaps,
//               shadow/display double buffering and a frame-done pulse.
//               Optional build macro SEVSEG_LEADING_ZERO_BLANK_EN blanks
//               leading zero digits (digit 0 always shows).
// Revision    : 1.0 - initial release
// ============================================================================
module sevseg_mux_driver #(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 1000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_MAX_CNT = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam int c_DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_ON_LAST    = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_DEAD_LAST  = c_CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [c_DIG_W-1:0] c_LAST_DIGIT = c_DIG_W'(NUM_DIGITS - 1);
    localparam bit                 c_SKIP_DEAD  = (DEAD_CYCLES == 0);

    localparam logic [0:0] c_ST_ON   = 1'b0;
    localparam logic [0:0] c_ST_DEAD = 1'b1;

    logic [0:0]              r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_DIG_W-1:0]      r_digit;
    logic                    r_wrapped;
    logic [4*NUM_DIGITS-1:0] r_shadow_hex;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;
    logic [4*NUM_DIGITS-1:0] r_disp_hex;
    logic [NUM_DIGITS-1:0]   r_disp_blank;

    logic                    w_on_done;
    logic                    w_enter_on;
    logic                    w_to_dead;
    logic [c_DIG_W-1:0]      w_next_digit;
    logic [NUM_DIGITS-1:0]   w_eff_blank;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_on_done    = (r_state == c_ST_ON) && (r_cnt == c_ON_LAST);
    assign w_enter_on   = (w_on_done && c_SKIP_DEAD) ||
                          ((r_state == c_ST_DEAD) && (r_cnt == c_DEAD_LAST));
    assign w_to_dead    = w_on_done && !c_SKIP_DEAD;
    assign w_next_digit = (r_digit == c_LAST_DIGIT) ? '0 : r_digit + 1'b1;

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic zero_above;
        zero_above  = 1'b1;
        w_eff_blank = r_disp_blank;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (r_disp_hex[4*k +: 4] == 4'h0);
            if (zero_above) begin
                w_eff_blank[k] = 1'b1;
            end
        end
    end
`else
    assign w_eff_blank = r_disp_blank;
`endif

    always_comb begin
        w_cur_nib   = 4'h0;
        w_cur_blank = 1'b0;
        w_an        = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_digit == c_DIG_W'(k)) begin
                w_cur_nib   = r_disp_hex[4*k +: 4];
                w_cur_blank = w_eff_blank[k];
                w_an[k]     = 1'b0;
            end
        end
    end

    // Display register only changes on ON entry, so a digit never changes mid-period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= c_ST_ON;
            r_cnt          <= '0;
            r_digit        <= '0;
            r_wrapped      <= 1'b0;
            r_shadow_hex   <= '0;
            r_shadow_blank <= '0;
            r_disp_hex     <= '0;
            r_disp_blank   <= '0;
        end else begin
            if (load) begin
                r_shadow_hex   <= hex_in;
                r_shadow_blank <= blank_in;
            end
            if (w_enter_on) begin
                r_state      <= c_ST_ON;
                r_cnt        <= '0;
                r_digit      <= w_next_digit;
                r_wrapped    <= (r_digit == c_LAST_DIGIT);
                r_disp_hex   <= r_shadow_hex;
                r_disp_blank <= r_shadow_blank;
            end else if (w_to_dead) begin
                r_state <= c_ST_DEAD;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg        <= 7'h7F;
            an         <= '1;
            frame_done <= 1'b0;
        end else if (r_state == c_ST_ON) begin
            seg        <= w_cur_blank ? 7'h7F : hex_to_seg(w_cur_nib);
            an         <= w_an;
            frame_done <= (r_cnt == '0) && (r_digit == '0) && r_wrapped;
        end else begin
            seg        <= 7'h7F;
            an         <= '1;
            frame_done <= 1'b0;
        end
    end

endmodule
`default_nettype wire
